// File: rtl/gate_sweep_pkg.sv
// Shared types and helpers for the gate sweep controller.
`timescale 1ns/1ps
package gate_sweep_pkg;

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  // Timer width to hold the settle count; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that flags the cycle on which its count runs out.
`timescale 1ns/1ps
module settle_timer #(
  parameter int unsigned     Width   = 1,
  parameter logic [Width-1:0] LoadVal = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);

  logic [Width-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LoadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // High when the decrement in progress brings the count to zero.
  assign expire = (count <= Width'(1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all input vectors onto a gate, samples after a settle time, checks a truth table.
// Define SWEEP_CAPTURE_EN to add the obs_tbl port holding the observed truth table.
`timescale 1ns/1ps
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned             N_IN     = 2,
  parameter int unsigned             SETTLE   = 1,
  parameter logic [(2**N_IN)-1:0]    EXPECTED = 4'b0001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      in_vec,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 sample_valid,
  output logic                 mismatch,
  output logic [N_IN:0]        err_count,
  output logic                 done,
`ifdef SWEEP_CAPTURE_EN
  output logic [(2**N_IN)-1:0] obs_tbl,
`endif
  output logic                 pass
);

  localparam int unsigned     TimerW  = timer_width(SETTLE);
  localparam logic [N_IN-1:0] LastVec = '1;
  localparam logic [N_IN:0]   MaxErr  = (N_IN + 1)'(2 ** N_IN);
  localparam state_e          StFirst = (SETTLE == 0) ? StSample : StSettle;

  state_e state;
  logic   start_ok;
  logic   miss;
  logic   tmr_load;
  logic   tmr_dec;
  logic   tmr_expire;

  assign start_ok = start && !abort && ((state == StIdle) || (state == StDone));
  assign miss     = (dut_out != EXPECTED[in_vec]);
  assign tmr_load = start_ok || ((state == StSample) && (in_vec != LastVec));
  assign tmr_dec  = (state == StSettle);

  settle_timer #(
    .Width   (TimerW),
    .LoadVal (TimerW'(SETTLE))
  ) u_settle_timer (
    .clk    (clk),
    .rst    (reset),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      in_vec       <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      mismatch     <= 1'b0;
      err_count    <= '0;
      done         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      mismatch     <= 1'b0;
      if (abort) begin
        // err_count deliberately survives an abort for post-mortem.
        state  <= StIdle;
        in_vec <= '0;
        busy   <= 1'b0;
        done   <= 1'b0;
      end else begin
        case (state)
          StIdle, StDone: begin
            if (start) begin
              in_vec    <= '0;
              err_count <= '0;
              done      <= 1'b0;
              busy      <= 1'b1;
              state     <= StFirst;
            end
          end
          StSettle: begin
            if (tmr_expire) state <= StSample;
          end
          StSample: begin
            sample_valid <= 1'b1;
            mismatch     <= miss;
            if (miss && (err_count != MaxErr)) err_count <= err_count + 1'b1;
            if (in_vec == LastVec) begin
              state <= StDone;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              in_vec <= in_vec + 1'b1;
              state  <= StFirst;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

`ifdef SWEEP_CAPTURE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obs_tbl <= '0;
    end else if (start_ok) begin
      obs_tbl <= '0;
    end else if (!abort && (state == StSample)) begin
      obs_tbl[in_vec] <= dut_out;
    end
  end
`endif

  assign pass = done && (err_count == '0);

endmodule
